// File: rtl/controller.sv
// Instruction-cycle sequencer: eight phases per instruction plus a HALTED state,
// with every control strobe decoded combinationally from the phase and the opcode.
module controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam logic [3:0] S_P0     = 4'd0;
    localparam logic [3:0] S_P1     = 4'd1;
    localparam logic [3:0] S_P2     = 4'd2;
    localparam logic [3:0] S_P3     = 4'd3;
    localparam logic [3:0] S_P4     = 4'd4;
    localparam logic [3:0] S_P5     = 4'd5;
    localparam logic [3:0] S_P6     = 4'd6;
    localparam logic [3:0] S_P7     = 4'd7;
    localparam logic [3:0] S_HALTED = 4'd8;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_aluop;

    assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

    always_comb begin
        w_next = S_P0;
        case (r_state)
            S_P0, S_P1, S_P2, S_P3, S_P5, S_P6: w_next = r_state + 4'd1;
            S_P4:     w_next = (opcode == OP_HLT) ? S_HALTED : S_P5;
            S_P7:     w_next = S_P0;
            S_HALTED: w_next = resume ? S_P0 : S_HALTED;
            default:  w_next = S_P0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_P0;
        end else begin
            r_state <= w_next;
        end
    end

    // Unused encodings 9..15 report phase 0 and drive no strobes
    assign phase = r_state[3] ? 3'd0 : r_state[2:0];

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (r_state)
            S_P0: begin
                sel = 1'b1;
            end
            S_P1: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            S_P2, S_P3: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            S_P4: begin
                inc_pc = 1'b1;
            end
            S_P5: begin
                rd = w_aluop;
            end
            S_P6: begin
                rd     = w_aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            S_P7: begin
                rd     = w_aluop;
                ld_ac  = w_aluop;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            S_HALTED: begin
                halt = 1'b1;
            end
            default: begin
                halt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Directed vector table for the per-opcode phase sequences, followed by randomized
// stimulus checked against a phase-counter reference model.
module tb_controller;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    // {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt}
    localparam logic [8:0] E_P0   = 9'b100000000;
    localparam logic [8:0] E_P1   = 9'b110000000;
    localparam logic [8:0] E_P23  = 9'b110100000;
    localparam logic [8:0] E_INC  = 9'b000001000;
    localparam logic [8:0] E_RD   = 9'b010000000;
    localparam logic [8:0] E_LDAC = 9'b010010000;
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_DE   = 9'b000000010;
    localparam logic [8:0] E_WRDE = 9'b001000010;
    localparam logic [8:0] E_LDPC = 9'b000000100;
    localparam logic [8:0] E_HALT = 9'b000000001;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
    logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [2:0] op;
        logic       zero;
        logic       resume;
        logic       chk;
        logic [8:0] en;
        logic [2:0] ph;
    } vec_t;

    vec_t vecs[$];

    controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .resume (resume),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] actual();
        return {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (sel rd wr ld_ir ld_ac inc_pc ld_pc data_e halt phase)",
                     name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic [2:0] op, input logic z, input logic res,
                     input logic chk, input logic [8:0] en, input logic [2:0] ph);
        vec_t t;
        t.rst = r; t.op = op; t.zero = z; t.resume = res; t.chk = chk; t.en = en; t.ph = ph;
        vecs.push_back(t);
    endtask

    // Common P0..P4 of every instruction
    task automatic fetch(input logic [2:0] op, input logic z);
        v(0, op, z, 0, 1, E_P0, 3'd0);
        v(0, op, z, 0, 1, E_P1, 3'd1);
        v(0, op, z, 0, 1, E_P23, 3'd2);
        v(0, op, z, 0, 1, E_P23, 3'd3);
        v(0, op, z, 0, 1, E_INC, 3'd4);
    endtask

    // Reference model: phase counter plus halted flag, outputs from the phase rules
    int  m_ph;
    bit  m_halted;

    function automatic logic [11:0] model_out(input int ph, input bit halted,
                                              input logic [2:0] op, input logic z);
        logic [8:0] e;
        bit alu;
        alu = (op >= 3'd2) && (op <= 3'd5);
        e = '0;
        if (halted) return {E_HALT, 3'd0};
        case (ph)
            0: e = E_P0;
            1: e = E_P1;
            2, 3: e = E_P23;
            4: e = E_INC;
            5: e[7] = alu;
            6: begin
                e[7] = alu;
                e[3] = (op == SKZ) && z;
                e[2] = (op == JMP);
                e[1] = (op == STO);
            end
            default: begin
                e[7] = alu;
                e[4] = alu;
                e[2] = (op == JMP);
                e[6] = (op == STO);
                e[1] = (op == STO);
            end
        endcase
        return {e, 3'(ph)};
    endfunction

    initial begin
        rst = 1'b1; opcode = ADD; zero = 1'b0; resume = 1'b0;

        v(1, ADD, 0, 0, 0, E_NONE, 3'd0);
        // ADD
        fetch(ADD, 0);
        v(0, ADD, 0, 0, 1, E_RD, 3'd5);
        v(0, ADD, 0, 0, 1, E_RD, 3'd6);
        v(0, ADD, 0, 0, 1, E_LDAC, 3'd7);
        // STO
        fetch(STO, 0);
        v(0, STO, 0, 0, 1, E_NONE, 3'd5);
        v(0, STO, 0, 0, 1, E_DE, 3'd6);
        v(0, STO, 0, 0, 1, E_WRDE, 3'd7);
        // SKZ, zero held high through every phase
        fetch(SKZ, 1);
        v(0, SKZ, 1, 0, 1, E_NONE, 3'd5);
        v(0, SKZ, 1, 0, 1, E_INC, 3'd6);
        v(0, SKZ, 1, 0, 1, E_NONE, 3'd7);
        // SKZ, zero low
        fetch(SKZ, 0);
        v(0, SKZ, 0, 0, 1, E_NONE, 3'd5);
        v(0, SKZ, 0, 0, 1, E_NONE, 3'd6);
        v(0, SKZ, 0, 0, 1, E_NONE, 3'd7);
        // JMP
        fetch(JMP, 0);
        v(0, JMP, 0, 0, 1, E_NONE, 3'd5);
        v(0, JMP, 0, 0, 1, E_LDPC, 3'd6);
        v(0, JMP, 0, 0, 1, E_LDPC, 3'd7);
        // HLT: halted for 10 cycles, then resume
        fetch(HLT, 0);
        for (int i = 0; i < 10; i++) v(0, HLT, 0, 0, 1, E_HALT, 3'd0);
        v(0, HLT, 0, 1, 1, E_HALT, 3'd0);
        v(0, ADD, 0, 0, 1, E_P0, 3'd0);
        v(0, ADD, 0, 0, 1, E_P1, 3'd1);
        v(0, ADD, 0, 0, 1, E_P23, 3'd2);
        v(0, ADD, 0, 0, 1, E_P23, 3'd3);
        v(0, ADD, 0, 0, 1, E_INC, 3'd4);
        v(0, ADD, 0, 0, 1, E_RD, 3'd5);
        v(0, ADD, 0, 0, 1, E_RD, 3'd6);
        v(0, ADD, 0, 0, 1, E_LDAC, 3'd7);
        // STO abandoned by reset in P6
        fetch(STO, 0);
        v(0, STO, 0, 0, 1, E_NONE, 3'd5);
        v(1, STO, 0, 0, 1, E_DE, 3'd6);
        v(0, STO, 0, 0, 1, E_P0, 3'd0);
        v(0, STO, 0, 0, 1, E_P1, 3'd1);
        // Reset beats resume while halted
        v(0, HLT, 0, 0, 1, E_P23, 3'd2);
        v(0, HLT, 0, 0, 1, E_P23, 3'd3);
        v(0, HLT, 0, 0, 1, E_INC, 3'd4);
        v(0, HLT, 0, 0, 1, E_HALT, 3'd0);
        v(1, HLT, 0, 1, 1, E_HALT, 3'd0);
        v(0, HLT, 0, 0, 1, E_P0, 3'd0);
        v(0, ADD, 0, 0, 1, E_P1, 3'd1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].zero; resume = vecs[i].resume;
            @(negedge clk);
            if (vecs[i].chk) check($sformatf("vec%0d", i), actual(), {vecs[i].en, vecs[i].ph});
            @(posedge clk);
            #1;
        end

        // Randomized run; first cycle resets so the model starts in step
        m_ph = 0;
        m_halted = 0;
        for (int c = 0; c < 600; c++) begin
            logic [11:0] exp;
            rst    = (c == 0) || ($urandom_range(0, 39) == 0);
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            resume = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (c > 0) begin
                exp = model_out(m_ph, m_halted, opcode, zero);
                check($sformatf("rand%0d", c), actual(), exp);
                checks++;
                if (rd && wr) begin
                    errors++;
                    $display("FAIL rdwr%0d: rd=%b wr=%b required not both 1", c, rd, wr);
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                m_ph = 0;
                m_halted = 0;
            end else if (m_halted) begin
                if (resume) m_halted = 0;
            end else if (m_ph == 4 && opcode == HLT) begin
                m_halted = 1;
                m_ph = 0;
            end else begin
                m_ph = (m_ph + 1) % 8;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
